branch_predictor_bht: RTL and testbench

- Branch history table of 2-bit saturating counters that supplies the fetch-stage branch_prediction bit to the branch decode unit.
- Trained by the execute stage when a conditional branch resolves (beq/bne/blt/fbeq/fbne/fblt/beqi/blti).
- Owns an init sequencer that walks the whole table after reset.
- Exposes a ready handshake so fetch knows when predictions are valid.

---
 rtl/branch_predictor_bht.sv | 86 ++++++++
 tb/tb_branch_predictor_bht.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: 2-bit saturating-counter branch history table with a
// post-reset init walk and ready handshake. Define GSHARE_EN to XOR a global
// history register into the lookup index.
module branch_predictor_bht #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 10,
    parameter int HIST_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [PC_W-1:0]  f_pc,
    output logic [IDX_W-1:0] f_idx,
    output logic             branch_prediction,
    output logic             ready,
    input  logic             r_valid,
    input  logic [IDX_W-1:0] r_idx,
    input  logic             r_taken
);

    typedef enum logic {INIT, RUN} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_init_ptr;
    logic             r_ready;
    logic [1:0]       r_bht [2**IDX_W];
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_cur;
    logic [1:0]       w_next;
    logic             w_pc_unused;

    assign w_pc_unused = ^f_pc[PC_W-1:IDX_W];

`ifdef GSHARE_EN
    logic [HIST_W-1:0] r_ghr;

    // history only advances on resolved branches once the table is live
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_ghr <= '0;
        else if (r_state == RUN && r_valid)
            r_ghr <= {r_ghr[HIST_W-2:0], r_taken};
    end

    assign w_idx = f_pc[IDX_W-1:0] ^ IDX_W'(r_ghr);
`else
    logic [HIST_W-1:0] w_hist_unused;

    assign w_hist_unused = '0;
    assign w_idx         = f_pc[IDX_W-1:0];
`endif

    // init walk: one entry per cycle, then RUN forever until the next reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= INIT;
            r_init_ptr <= '0;
            r_ready    <= 1'b0;
        end else if (r_state == INIT) begin
            r_init_ptr <= r_init_ptr + 1'b1;
            if (&r_init_ptr) begin
                r_state <= RUN;
                r_ready <= 1'b1;
            end
        end
    end

    // saturating next value for the resolving entry
    always_comb begin
        w_cur  = r_bht[r_idx];
        w_next = r_taken ? (&w_cur ? w_cur : w_cur + 2'd1)
                         : (|w_cur ? w_cur - 2'd1 : w_cur);
    end

    // single write port: init walk owns it in INIT, training owns it in RUN
    always_ff @(posedge clk) begin
        if (r_state == INIT)
            r_bht[r_init_ptr] <= 2'b01;
        else if (r_valid)
            r_bht[r_idx] <= w_next;
    end

    assign ready             = r_ready;
    assign f_idx             = r_ready ? w_idx : '0;
    assign branch_prediction = r_ready & r_bht[w_idx][1];

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: directed checks of init timing, training, saturation and reset behaviour.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] f_pc;
    logic [3:0]  f_idx;
    logic        branch_prediction;
    logic        ready;
    logic        r_valid;
    logic [3:0]  r_idx;
    logic        r_taken;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cnt;

    branch_predictor_bht #(.PC_W(32), .IDX_W(4), .HIST_W(4)) dut (
        .clk(clk),
        .rstn(rstn),
        .f_pc(f_pc),
        .f_idx(f_idx),
        .branch_prediction(branch_prediction),
        .ready(ready),
        .r_valid(r_valid),
        .r_idx(r_idx),
        .r_taken(r_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [3:0] idx, input logic taken);
        r_valid = 1'b1;
        r_idx   = idx;
        r_taken = taken;
        tick();
        r_valid = 1'b0;
    endtask

    task automatic pred(input string tag, input logic [31:0] pc, input logic exp);
        f_pc = pc;
        #1;
        chk(tag, {31'd0, branch_prediction}, {31'd0, exp});
    endtask

    task automatic init_wait(input string tag);
        cnt = 0;
        while (!ready && cnt < 40) begin
            tick();
            cnt++;
        end
        chk(tag, cnt, 16);
    endtask

    initial begin
        rstn    = 1'b0;
        f_pc    = 32'd3;
        r_valid = 1'b0;
        r_idx   = '0;
        r_taken = 1'b0;
        tick();
        tick();
        chk("rst_ready", {31'd0, ready}, 0);
        chk("rst_pred", {31'd0, branch_prediction}, 0);
        chk("rst_fidx", {28'd0, f_idx}, 0);
        r_valid = 1'b1;
        r_idx   = 4'd2;
        r_taken = 1'b1;
        rstn    = 1'b1;
        init_wait("init_len");
        r_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            f_pc = i;
            #1;
            chk("init_pred", {31'd0, branch_prediction}, 0);
            chk("init_fidx", {28'd0, f_idx}, i);
        end
`ifdef GSHARE_EN
        upd(4'd0, 1'b1);
        upd(4'd0, 1'b1);
        f_pc = 32'd1;
        #1;
        chk("gs_fidx", {28'd0, f_idx}, 2);
        chk("gs_pred", {31'd0, branch_prediction}, 0);
        r_valid = 1'b1;
        r_idx   = 4'd0;
        r_taken = 1'b1;
        #1;
        chk("gs_old_ghr", {28'd0, f_idx}, 2);
        tick();
        r_valid = 1'b0;
        chk("gs_new_ghr", {28'd0, f_idx}, 6);
        rstn    = 1'b0;
        r_valid = 1'b1;
        tick();
        rstn = 1'b1;
        init_wait("gs_reinit_len");
        r_valid = 1'b0;
        f_pc = 32'd1;
        #1;
        chk("gs_ghr_clr", {28'd0, f_idx}, 1);
`else
        pred("init_drop", 32'd2, 1'b0);
        upd(4'd3, 1'b1);
        pred("t3_wt", 32'd3, 1'b1);
        upd(4'd3, 1'b0);
        pred("t3_wn", 32'd3, 1'b0);
        upd(4'd3, 1'b1);
        upd(4'd3, 1'b1);
        upd(4'd3, 1'b1);
        pred("t3_st", 32'd3, 1'b1);
        upd(4'd3, 1'b0);
        pred("t3_st_nt", 32'd3, 1'b1);
        pred("t3_other", 32'd4, 1'b0);
        for (int i = 0; i < 5; i++) upd(4'd5, 1'b0);
        pred("s5_sn", 32'd5, 1'b0);
        upd(4'd5, 1'b1);
        pred("s5_t1", 32'd5, 1'b0);
        upd(4'd5, 1'b1);
        pred("s5_t2", 32'd5, 1'b1);
        upd(4'd15, 1'b1);
        pred("e15_t", 32'h0000_001f, 1'b1);
        f_pc    = 32'd7;
        r_valid = 1'b1;
        r_idx   = 4'd7;
        r_taken = 1'b1;
        #1;
        chk("rbw_same", {31'd0, branch_prediction}, 0);
        tick();
        r_valid = 1'b0;
        chk("rbw_next", {31'd0, branch_prediction}, 1);
        upd(4'd2, 1'b1);
        upd(4'd2, 1'b1);
        pred("t2_st", 32'd2, 1'b1);
        chk("run_ready", {31'd0, ready}, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, ready}, 0);
        chk("mid_rst_pred", {31'd0, branch_prediction}, 0);
        tick();
        rstn = 1'b1;
        init_wait("reinit_len");
        pred("reinit_t2", 32'd2, 1'b0);
        pred("reinit_t3", 32'd3, 1'b0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
